// File: rtl/des_frame_ctrl.sv
// Sequencing controller for the serial-to-parallel deserializer: sync hunt, frame load strobe, valid/ready handoff.
// Optional frame counter output enabled by defining DES_FRAME_CNT_EN.
module des_frame_ctrl #(
    parameter int unsigned FRAME_W = 32,
    parameter int unsigned SYNC_W = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5
) (
    input  logic clock,
    input  logic rst_n,
    input  logic start,
    input  logic resync,
    input  logic din,
    output logic des_enable,
    output logic des_load,
    output logic locked,
    output logic frame_valid,
    input  logic frame_ready,
    output logic overrun,
    input  logic overrun_clr
`ifdef DES_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HUNT   = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic [1:0]        state;
    // Only SYNC_W-1 bits of history are kept; the current din completes the window.
    logic [SYNC_W-2:0] sync_sr;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SYNC_W-1:0] window;
    logic              match;
    logic              hunt_load;
    logic              lock_load;

    always_comb begin
        window     = {sync_sr, din};
        match      = (window == SYNC_PATTERN);
        hunt_load  = (state == S_HUNT) && match;
        lock_load  = (state == S_LOCKED) && !resync && (bit_cnt == CNT_LAST);
        des_load   = hunt_load || lock_load;
        des_enable = (state != S_IDLE);
        locked     = (state == S_LOCKED);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sync_sr <= '0;
            bit_cnt <= '0;
        end else if (!start) begin
            state   <= S_IDLE;
            sync_sr <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_HUNT;
                S_HUNT: begin
                    sync_sr <= window[SYNC_W-2:0];
                    if (match) begin
                        state   <= S_LOCKED;
                        bit_cnt <= '0;
                    end
                end
                S_LOCKED: begin
                    if (resync) begin
                        state   <= S_HUNT;
                        bit_cnt <= '0;
                        sync_sr <= '0;
                    end else if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A load landing on an unaccepted frame overwrites it; set beats clear.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (lock_load) begin
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end

            if (lock_load && frame_valid && !frame_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef DES_FRAME_CNT_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (start && ((state == S_IDLE) || ((state == S_LOCKED) && resync))) begin
            frame_cnt <= '0;
        end else if (lock_load) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_des_frame_ctrl.sv
// Directed bench for des_frame_ctrl: table-driven idle/acquisition, then framing, overrun, resync and async reset sequences.
module tb_des_frame_ctrl;

    logic clock = 1'b0;
    logic rst_n;
    logic start, resync, din, frame_ready, overrun_clr;
    logic des_enable, des_load, locked, frame_valid, overrun;
`ifdef DES_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int n_checks = 0;
    int n_err = 0;

    des_frame_ctrl #(.FRAME_W(32), .SYNC_W(8), .SYNC_PATTERN(8'hA5)) dut (
        .clock(clock),
        .rst_n(rst_n),
        .start(start),
        .resync(resync),
        .din(din),
        .des_enable(des_enable),
        .des_load(des_load),
        .locked(locked),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
`ifdef DES_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Expected vector packing: {des_enable, des_load, locked, frame_valid, overrun}
    typedef struct {
        logic       st;
        logic       rs;
        logic       d;
        logic       rdy;
        logic       clr;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got en/ld/lk/fv/ov=%b expected %b", name, got, exp);
        end
    endtask

    task automatic step(input logic st, input logic rs, input logic d, input logic rdy,
                        input logic clr, input logic [4:0] exp, input string name);
        @(negedge clock);
        start       = st;
        resync      = rs;
        din         = d;
        frame_ready = rdy;
        overrun_clr = clr;
        #1;
        chk(name, {des_enable, des_load, locked, frame_valid, overrun}, exp);
    endtask

    initial begin
        logic [12:0] acq;
        logic [7:0]  pat;
        vec_t        v;

        rst_n = 1'b0; start = 1'b0; resync = 1'b0; din = 1'b0;
        frame_ready = 1'b0; overrun_clr = 1'b0;

        // 5 lead-in bits 00110 then 0xA5 MSB first; no earlier window equals 0xA5
        acq = 13'b0011010100101;
        pat = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, $sformatf("idle%0d", i)};
            tbl.push_back(v);
        end
        v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, "start_idle"};
        tbl.push_back(v);
        for (int b = 0; b < 13; b++) begin
            v = '{1'b1, 1'b0, acq[12-b], 1'b0, 1'b0,
                  (b == 12) ? 5'b11000 : 5'b10000, $sformatf("hunt%0d", b)};
            tbl.push_back(v);
        end

        #1;
        chk("reset_outputs", {des_enable, des_load, locked, frame_valid, overrun}, 5'b00000);
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;

        foreach (tbl[i])
            step(tbl[i].st, tbl[i].rs, tbl[i].d, tbl[i].rdy, tbl[i].clr, tbl[i].exp, tbl[i].name);

        // Framing: loads at lock+31/63/95, frame_valid one cycle after each
        for (int i = 0; i <= 96; i++)
            step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b1, 1'b0,
                 {1'b1, (i % 32) == 31, 1'b1, (i == 32) || (i == 64) || (i == 96), 1'b0},
                 $sformatf("frame%0d", i));
`ifdef DES_FRAME_CNT_EN
        chk("frame_cnt_after3", {4'b0, frame_cnt == 16'd3}, 5'b00001);
`endif

        // Overrun: bit_cnt = (1+j)%32, ready low across two loads, then clear and accept
        for (int j = 0; j <= 66; j++)
            step(1'b1, 1'b0, 1'($urandom_range(1)), j >= 65, j == 64,
                 {1'b1, (j == 30) || (j == 62), 1'b1, (j >= 31) && (j <= 65), (j >= 63) && (j <= 64)},
                 $sformatf("ovr%0d", j));

        // Resync collision at bit_cnt 31 (k=27), then re-send 0xA5
        for (int k = 0; k <= 35; k++)
            step(1'b1, k == 27, (k >= 28) ? pat[7-(k-28)] : 1'($urandom_range(1)), 1'b1, 1'b0,
                 {1'b1, k == 35, k <= 27, 1'b0, 1'b0},
                 $sformatf("resync%0d", k));
`ifdef DES_FRAME_CNT_EN
        chk("frame_cnt_hunt_clear", {4'b0, frame_cnt == 16'd0}, 5'b00001);
`endif

        // Build up valid+overrun, stop at bit_cnt 17
        for (int m = 0; m <= 81; m++)
            step(1'b1, 1'b0, 1'($urandom_range(1)), 1'b0, 1'b0,
                 {1'b1, (m % 32) == 31, 1'b1, m >= 32, m >= 64},
                 $sformatf("pre_rst%0d", m));

        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {des_enable, des_load, locked, frame_valid, overrun}, 5'b00000);
`ifdef DES_FRAME_CNT_EN
        chk("async_reset_cnt", {4'b0, frame_cnt == 16'd0}, 5'b00001);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
